// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// The branch target table is fixed at build time; unused slots are zero.
package pc_seq_pkg;

  localparam int PC_W      = 10;
  localparam int LUT_IDX_W = 4;
  localparam int CNT_W     = 16;
  localparam int LUT_DEPTH = 2 ** LUT_IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } seq_state_t;

  localparam logic [PC_W-1:0] BRANCH_LUT [LUT_DEPTH] = '{
    10'd12, 10'd40, 10'd3, 10'd1023,
    10'd0,  10'd0,  10'd0, 10'd0,
    10'd0,  10'd0,  10'd0, 10'd0,
    10'd0,  10'd0,  10'd0, 10'd0
  };

endpackage

// File: rtl/pc_sequencer_branch_lut.sv
// Combinational lookup from the decoder's branch immediate to an absolute
// fetch address.
module branch_lut
  import pc_seq_pkg::*;
(
  input  logic [LUT_IDX_W-1:0] branch_idx,
  output logic [PC_W-1:0]      target
);

  assign target = BRANCH_LUT[branch_idx];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and run-control sequencer feeding the instruction ROM.
// Retired-instruction counter width is overridable; it saturates, never wraps.
//
//   state  | meaning
//   IDLE   | post-reset, waiting for start
//   LOAD   | armed by start; PC/count/halt cleared, launches when start falls
//   RUN    | fetching; one instruction retires per non-stalled cycle
//   HALTED | HALT retired; PC parked on it until the next start
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_W
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 halt_req,
  input  logic                 branch_en,
  input  logic                 branch_take,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  input  logic                 stall,
  output logic [PC_W-1:0]      PC,
  output logic                 halt,
  output logic                 running,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  seq_state_t           r_state;
  logic [PC_W-1:0]      r_pc;
  logic                 r_halt;
  logic                 r_running;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic [PC_W-1:0]      w_branch_target;
  logic [CNT_WIDTH-1:0] w_cnt_next;

  branch_lut u_branch_lut (
    .branch_idx (branch_idx),
    .target     (w_branch_target)
  );

  assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1);

  // Entering LOAD from any state clears PC, count and halt on that same edge.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_halt    <= 1'b0;
      r_running <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) r_state <= LOAD;
        end

        LOAD: begin
          r_pc   <= '0;
          r_cnt  <= '0;
          r_halt <= 1'b0;
          if (!start) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end

        RUN: begin
          if (start) begin
            r_state   <= LOAD;
            r_running <= 1'b0;
            r_pc      <= '0;
            r_cnt     <= '0;
          end else if (stall) begin
            r_state <= RUN;
          end else if (halt_req) begin
            r_state   <= HALTED;
            r_halt    <= 1'b1;
            r_running <= 1'b0;
            r_cnt     <= w_cnt_next;
          end else if (branch_en && branch_take) begin
            r_pc  <= w_branch_target;
            r_cnt <= w_cnt_next;
          end else begin
            r_pc  <= r_pc + PC_W'(1);
            r_cnt <= w_cnt_next;
          end
        end

        HALTED: begin
          if (start) begin
            r_state <= LOAD;
            r_halt  <= 1'b0;
            r_pc    <= '0;
            r_cnt   <= '0;
          end
        end

        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign PC        = r_pc;
  assign halt      = r_halt;
  assign running   = r_running;
  assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: reset/launch table, directed corner sequences and
// random traffic against a behavioural model; a narrow-counter copy checks saturation.
module tb_pc_sequencer;

  localparam int NUM_PC   = 1024;
  localparam int CNT_MAX  = 65535;
  localparam int CNT4_MAX = 15;

  logic        CLK = 1'b0;
  logic        Reset, start, halt_req, branch_en, branch_take, stall;
  logic [3:0]  branch_idx;
  logic [9:0]  PC, PC4;
  logic        halt, running, halt4, running4;
  logic [15:0] instr_cnt;
  logic [3:0]  instr_cnt4;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0 idle, 1 armed, 2 running, 3 halted
  int m_mode, m_pc, m_halt, m_cnt, m_cnt4;
  int tb_lut [16] = '{12, 40, 3, 1023, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  always #5 CLK = ~CLK;

  pc_sequencer dut (
    .CLK(CLK), .Reset(Reset), .start(start), .halt_req(halt_req),
    .branch_en(branch_en), .branch_take(branch_take), .branch_idx(branch_idx),
    .stall(stall), .PC(PC), .halt(halt), .running(running), .instr_cnt(instr_cnt)
  );

  pc_sequencer #(.CNT_WIDTH(4)) dut4 (
    .CLK(CLK), .Reset(Reset), .start(start), .halt_req(halt_req),
    .branch_en(branch_en), .branch_take(branch_take), .branch_idx(branch_idx),
    .stall(stall), .PC(PC4), .halt(halt4), .running(running4), .instr_cnt(instr_cnt4)
  );

  typedef struct {
    logic rst, st;
    int   e_pc, e_halt, e_run, e_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v < mx) ? v + 1 : mx;
  endfunction

  function automatic void clear_model();
    m_pc = 0; m_halt = 0; m_cnt = 0; m_cnt4 = 0;
  endfunction

  function automatic void model_edge();
    if (Reset) begin
      m_mode = 0; clear_model();
    end else if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      clear_model();
      if (!start) m_mode = 2;
    end else if (m_mode == 2) begin
      if (start) begin
        m_mode = 1; clear_model();
      end else if (!stall) begin
        m_cnt  = sat(m_cnt, CNT_MAX);
        m_cnt4 = sat(m_cnt4, CNT4_MAX);
        if (halt_req) begin
          m_mode = 3; m_halt = 1;
        end else if (branch_en && branch_take) begin
          m_pc = tb_lut[branch_idx];
        end else begin
          m_pc = (m_pc + 1) % NUM_PC;
        end
      end
    end else begin
      if (start) begin
        m_mode = 1; clear_model();
      end
    end
  endfunction

  task automatic clr_in();
    Reset = 0; start = 0; halt_req = 0; branch_en = 0; branch_take = 0;
    branch_idx = 0; stall = 0;
  endtask

  task automatic edge_only();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic step();
    edge_only();
    chk("pc", int'(PC), m_pc);
    chk("halt", int'(halt), m_halt);
    chk("running", int'(running), (m_mode == 2) ? 1 : 0);
    chk("cnt", int'(instr_cnt), m_cnt);
    chk("cnt_sat4", int'(instr_cnt4), m_cnt4);
    chk("pc4", int'(PC4), m_pc);
  endtask

  task automatic launch();
    clr_in(); start = 1; step();
    start = 0; step();
  endtask

  task automatic run_to(input int target);
    clr_in();
    for (int i = 0; i < 1100 && m_pc != target; i++) step();
    chk("run_to_reached", m_pc, target);
  endtask

  initial begin
    clr_in();
    Reset = 1;
    m_mode = 0; clear_model();

    for (int i = 0; i < 10; i++) vecs[i] = '{rst: 0, st: 0, e_pc: i - 4, e_halt: 0, e_run: 1, e_cnt: i - 4};
    vecs[0] = '{rst: 1, st: 0, e_pc: 0, e_halt: 0, e_run: 0, e_cnt: 0};
    vecs[1] = '{rst: 1, st: 0, e_pc: 0, e_halt: 0, e_run: 0, e_cnt: 0};
    vecs[2] = '{rst: 0, st: 1, e_pc: 0, e_halt: 0, e_run: 0, e_cnt: 0};
    vecs[3] = '{rst: 0, st: 1, e_pc: 0, e_halt: 0, e_run: 0, e_cnt: 0};
    vecs[4] = '{rst: 0, st: 0, e_pc: 0, e_halt: 0, e_run: 1, e_cnt: 0};

    #2;
    for (int i = 0; i < 10; i++) begin
      Reset = vecs[i].rst; start = vecs[i].st;
      edge_only();
      chk($sformatf("vec%0d_pc", i), int'(PC), vecs[i].e_pc);
      chk($sformatf("vec%0d_halt", i), int'(halt), vecs[i].e_halt);
      chk($sformatf("vec%0d_running", i), int'(running), vecs[i].e_run);
      chk($sformatf("vec%0d_cnt", i), int'(instr_cnt), vecs[i].e_cnt);
    end

    // Taken and not-taken branches
    run_to(7);
    branch_en = 1; branch_take = 1; branch_idx = 1; step();
    chk("br_taken_pc", int'(PC), 40);
    clr_in(); step();
    branch_en = 1; branch_take = 0; branch_idx = 1; step();
    chk("br_not_taken_pc", int'(PC), 42);

    // Halt beats a simultaneous branch, then everything is frozen
    launch();
    run_to(20);
    halt_req = 1; branch_en = 1; branch_take = 1; branch_idx = 0; step();
    chk("halt_rise", int'(halt), 1);
    chk("halt_pc", int'(PC), 20);
    chk("halt_cnt", int'(instr_cnt), 21);
    for (int i = 0; i < 3; i++) begin
      halt_req = 1'($urandom); branch_en = 1'($urandom); branch_take = 1'($urandom);
      stall = 1'($urandom); branch_idx = 4'($urandom);
      step();
      chk("halted_pc_hold", int'(PC), 20);
      chk("halted_cnt_hold", int'(instr_cnt), 21);
    end
    chk("cnt4_saturated", int'(instr_cnt4), 15);

    // Restart from HALTED
    clr_in(); start = 1; step();
    chk("restart_halt_clear", int'(halt), 0);
    start = 0; step();
    chk("restart_pc0", int'(PC), 0);
    chk("restart_running", int'(running), 1);

    // Stall masks a pending halt
    run_to(9);
    stall = 1; halt_req = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", int'(PC), 9);
      chk("stall_cnt", int'(instr_cnt), 9);
      chk("stall_halt", int'(halt), 0);
    end
    stall = 0; step();
    chk("stall_release_halt", int'(halt), 1);
    chk("stall_release_cnt", int'(instr_cnt), 10);

    // Reset while HALTED
    clr_in(); Reset = 1; step();
    chk("rst_halted_halt", int'(halt), 0);
    Reset = 0; step();
    chk("rst_idle_running", int'(running), 0);

    // Branch to top of ROM, then wrap
    launch();
    branch_en = 1; branch_take = 1; branch_idx = 3; step();
    chk("br_top_pc", int'(PC), 1023);
    clr_in(); step();
    chk("wrap_pc", int'(PC), 0);

    // Reset mid-run
    run_to(30);
    Reset = 1; step();
    chk("rst_run_pc", int'(PC), 0);
    chk("rst_run_running", int'(running), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      Reset       = ($urandom_range(0, 149) == 0);
      start       = ($urandom_range(0, 39) == 0);
      halt_req    = ($urandom_range(0, 24) == 0);
      branch_en   = ($urandom_range(0, 3) == 0);
      branch_take = 1'($urandom);
      branch_idx  = 4'($urandom_range(0, 15));
      stall       = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program counter and run-control sequencer for the single-cycle core; sits directly upstream of instruction ROM and decode.
- Consumes the top-level start pulse and the decoder's halt/branch signals. Produces the fetch address PC, the halt done-flag, and a retired-instruction count.
- Absolute branch targets come from a constant lookup table indexed by a small immediate.

Parameters:
- PC_W, 10, width of PC / instruction ROM address.
- LUT_IDX_W, 4, branch-index width; the LUT has 2**LUT_IDX_W entries.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- CLK  input  1  system clock, rising-edge.
- Reset  input  1  synchronous, active-high; dominates all other inputs.
- start  input  1  level; held high to arm/restart, program launches on its falling edge.
- halt_req  input  1  decoder: current instruction is HALT.
- branch_en  input  1  decoder: current instruction is a conditional branch.
- branch_take  input  1  ALU condition flag qualifying branch_en.
- branch_idx  input  LUT_IDX_W  LUT index for the branch target.
- stall  input  1  freeze request (multi-cycle memory op).
- PC  output  PC_W  fetch address, registered.
- halt  output  1  done flag, registered.
- running  output  1  high in RUN state.
- instr_cnt  output  CNT_W  retired (non-stalled RUN) cycles, saturating.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high.
- States: IDLE, LOAD, RUN, HALTED. Encoding is a 2-bit enum.
- Reset: state=IDLE, PC=0, halt=0, running=0, instr_cnt=0. Reset mid-RUN or mid-HALTED takes effect on the same edge.
- IDLE: start=1 -> LOAD; otherwise stay IDLE. Outputs hold their reset values.
- LOAD: PC=0, instr_cnt=0, halt=0 on every cycle. Stay while start=1. start=0 -> RUN on the next edge, with PC=0 for the first fetch.
- RUN: running=1. Per edge, in priority order:
  - start=1 -> LOAD (restart).
  - stall=1 -> PC, instr_cnt and state hold. halt_req and branch are ignored this cycle.
  - halt_req=1 -> HALTED. PC holds (points at the HALT instruction). instr_cnt+1.
  - branch_en & branch_take -> PC = LUT[branch_idx]. instr_cnt+1.
  - Otherwise PC = PC+1, wrapping modulo 2**PC_W (max -> 0). instr_cnt+1.
- instr_cnt saturates at all-ones and does not wrap.
- branch_en with branch_take=0 is a plain increment.
- halt_req and branch_en asserted together: halt wins.
- Latency:
  - PC update is 1 cycle: the decision in cycle n appears on PC in cycle n+1.
  - halt rises on the same edge that enters HALTED.
- HALTED: halt=1, running=0, PC and instr_cnt held. start=1 -> LOAD, which clears halt on that edge. All other inputs are ignored.
- LUT: combinational, constant contents from the package; PC_W-wide entries. Unused entries = 0.

Decomposition:
- Package pc_seq_pkg holds:
  - enum seq_state_t {IDLE, LOAD, RUN, HALTED};
  - parameters PC_W, LUT_IDX_W, CNT_W;
  - constant array BRANCH_LUT[2**LUT_IDX_W], with entries 0..3 = 10'd12, 10'd40, 10'd3, 10'd1023.
- One sub-module, branch_lut: combinational, maps branch_idx -> target.
- FSM, PC register and counter all live in pc_sequencer.

Test Plan:
- Reset=1 for 2 cycles, then start=1 for 2 cycles, then start=0; run 5 cycles with no control inputs -> PC sequence 0,1,2,3,4,5; instr_cnt=5; halt=0; running=1.
- In RUN at PC=7, branch_en=1, branch_take=1, branch_idx=1 -> next PC=40. At PC=41, branch_en=1, branch_take=0 -> next PC=42.
- At PC=20, halt_req=1 together with branch_en=1, branch_take=1 -> halt=1 on the next edge, PC stays 20, instr_cnt increments once. Later edges: PC, halt and instr_cnt unchanged.
- At PC=9, stall=1 for 3 cycles with halt_req=1 -> PC stays 9, instr_cnt frozen, halt=0. Release stall with halt_req=1 -> HALTED.
- Branch to idx 3 (PC=1023), then 1 idle cycle -> PC wraps to 0. Separately, force instr_cnt near 16'hFFFF and run -> it saturates at 16'hFFFF.
- Reset=1 asserted while HALTED, and also mid-RUN at PC=30 -> next edge PC=0, halt=0, state IDLE. From HALTED, start=1 then 0 -> halt clears on the start edge and the run resumes from PC=0.
